mem_bus_arbiter: RTL

Shares one external single-port memory bus between the CPU instruction-fetch requester and the CPU data requester. Each requester uses a hold-until-ack handshake. The block runs a 3-state controller: data has fixed priority, and a starvation counter guarantees fetch progress. It sits between the core's IF/MEM bus masters and the SRAM/peripheral bridge.

---
 rtl/cpu_defs.sv | 24 ++
 rtl/arb_starve_pick.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared arbiter types: controller states, bus owner encoding and the
// request fields latched onto the memory bus at grant time.
package cpu_defs;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INST_BUSY = 2'd1,
        DATA_BUSY = 2'd2
    } ArbState_t;

    typedef logic ArbOwner_t;

    localparam ArbOwner_t   OWNER_INST   = 1'b0;
    localparam ArbOwner_t   OWNER_DATA   = 1'b1;
    localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } MemBusReq_t;

endpackage

// File: rtl/arb_starve_pick.sv
// Winner select for the fetch/data arbiter plus the saturating starvation
// counter that forces a fetch grant after STARVE_LIMIT data grants.
module arb_starve_pick #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_idle,
    input  logic i_inst_req,
    input  logic i_data_req,
    output logic o_pick_data
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_cnt;
    logic       w_grant;

    assign w_grant     = i_idle && (i_inst_req || i_data_req);
    assign o_pick_data = i_data_req && !(i_inst_req && (r_cnt == LIMIT));

    // Only data grants that bypass a waiting fetch count toward starvation.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_grant) begin
            if (!o_pick_data) begin
                r_cnt <= '0;
            end else if (i_inst_req && (r_cnt != LIMIT)) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter for a single-port memory bus: data has priority, fetch is
// protected from starvation. Define ARB_TIMEOUT_EN to add the BUSY watchdog.
module mem_bus_arbiter
    import cpu_defs::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inst_req,
    input  logic [31:0] i_inst_addr,
    output logic [31:0] o_inst_rdata,
    output logic        o_inst_ack,
    input  logic        i_data_req,
    input  logic        i_data_we,
    input  logic [3:0]  i_data_be,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    output logic [31:0] o_data_rdata,
    output logic        o_data_ack,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_mem_owner,
    output logic        o_bus_err
);
    ArbState_t  r_state;
    ArbState_t  w_state_nxt;
    MemBusReq_t r_req;
    MemBusReq_t w_req_sel;
    ArbOwner_t  r_owner;
    logic       w_idle;
    logic       w_grant;
    logic       w_pick_data;
    logic       w_timeout;
    logic       w_done;
    logic [31:0] w_rdata;

    assign w_idle  = (r_state == IDLE);
    assign w_grant = w_idle && (i_inst_req || i_data_req);

    arb_starve_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_idle      (w_idle),
        .i_inst_req  (i_inst_req),
        .i_data_req  (i_data_req),
        .o_pick_data (w_pick_data)
    );

`ifdef ARB_TIMEOUT_EN
    logic [9:0] r_wd;

    // Holds 0 in IDLE, so the first BUSY cycle counts as 0.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_idle) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 10'd1;
        end
    end

    assign w_timeout = !w_idle && (r_wd == 10'(TIMEOUT_CYCLES - 1));
    assign o_bus_err = w_timeout && !i_mem_ack && !i_rst;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_timeout        = 1'b0;
    assign o_bus_err        = 1'b0;
`endif

    assign w_done = !w_idle && (i_mem_ack || w_timeout);

    always_comb begin
        w_req_sel = '0;
        if (w_pick_data) begin
            w_req_sel.we    = i_data_we;
            w_req_sel.be    = i_data_be;
            w_req_sel.addr  = i_data_addr;
            w_req_sel.wdata = i_data_wdata;
        end else begin
            w_req_sel.we    = 1'b0;
            w_req_sel.be    = 4'hF;
            w_req_sel.addr  = i_inst_addr;
            w_req_sel.wdata = 32'h0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:                 if (w_grant) w_state_nxt = w_pick_data ? DATA_BUSY : INST_BUSY;
            INST_BUSY, DATA_BUSY: if (w_done)  w_state_nxt = IDLE;
            default:              w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_req   <= '0;
            r_owner <= OWNER_INST;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_req   <= w_req_sel;
                r_owner <= w_pick_data ? OWNER_DATA : OWNER_INST;
            end
        end
    end

    assign o_mem_req   = !w_idle;
    assign o_mem_we    = r_req.we;
    assign o_mem_be    = r_req.be;
    assign o_mem_addr  = r_req.addr;
    assign o_mem_wdata = r_req.wdata;
    assign o_mem_owner = r_owner;

    // A real mem_ack wins over a simultaneous timeout.
    assign w_rdata      = (w_timeout && !i_mem_ack) ? BUS_ERR_DATA : i_mem_rdata;
    assign o_inst_rdata = w_rdata;
    assign o_data_rdata = w_rdata;
    assign o_inst_ack   = w_done && !i_rst && (r_state == INST_BUSY);
    assign o_data_ack   = w_done && !i_rst && (r_state == DATA_BUSY);

endmodule
